// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads a 16-bit little-endian instruction as two
// byte accesses starting at the PC and requests two PC increments per fetch.
module instruction_fetch_unit (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] PCIn,
   input  logic [7:0]  MemData,
   input  logic        MemReady,
   output logic [15:0] MemAddr,
   output logic        MemRead,
   output logic        PCInc,
   output logic [15:0] IROut,
   output logic        Valid,
   output logic        Busy
);

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned INSTR_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FETCH_LO = 2'd1,
      ST_FETCH_HI = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDR_W-1:0]    r_addr;
   logic [INSTR_W-1:0]   r_ir;
   logic                 w_latch_pc;
   logic                 w_load_lo;
   logic                 w_load_hi;

   // State register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Address and instruction registers; PCIn is only captured on a Start-accepting edge
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_addr <= '0;
         r_ir   <= '0;
      end else begin
         if (w_latch_pc) begin
            r_addr <= PCIn;
         end else if (w_load_lo) begin
            r_addr <= r_addr + ADDR_W'(1);
         end
         if (w_load_lo) begin
            r_ir[BYTE_W-1:0] <= MemData;
         end
         if (w_load_hi) begin
            r_ir[INSTR_W-1:BYTE_W] <= MemData;
         end
      end
   end

   // Next-state and output decode
   always_comb begin
      w_state_nxt = r_state;
      w_latch_pc  = 1'b0;
      w_load_lo   = 1'b0;
      w_load_hi   = 1'b0;
      MemAddr     = '0;
      MemRead     = 1'b0;
      PCInc       = 1'b0;
      Valid       = 1'b0;
      Busy        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_latch_pc  = 1'b1;
               w_state_nxt = ST_FETCH_LO;
            end
         end
         ST_FETCH_LO: begin
            Busy    = 1'b1;
            MemAddr = r_addr;
            MemRead = 1'b1;
            if (MemReady) begin
               PCInc       = 1'b1;
               w_load_lo   = 1'b1;
               w_state_nxt = ST_FETCH_HI;
            end
         end
         ST_FETCH_HI: begin
            Busy    = 1'b1;
            MemAddr = r_addr;
            MemRead = 1'b1;
            if (MemReady) begin
               PCInc       = 1'b1;
               w_load_hi   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            Valid = 1'b1;
            if (Start) begin
               w_latch_pc  = 1'b1;
               w_state_nxt = ST_FETCH_LO;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign IROut = r_ir;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have one clock, Clock (input, 1), rising-edge; reset is asynchronous and active-high, Reset (input, 1).
REQ-002 Start  input  1  request to fetch one 16-bit instruction; sampled on rising Clock edge.
REQ-003 PCIn  input  16  current PC value from the address register file's OutC.
REQ-004 MemData  input  8  byte returned by memory for MemAddr; valid in the same cycle when MemReady=1.
REQ-005 MemReady  input  1  memory byte-accept handshake; 0 stalls the current byte.
REQ-006 MemAddr  output  16  byte address presented to memory.
REQ-007 MemRead  output  1  memory read enable (chip select, write disabled).
REQ-008 PCInc  output  1  one-cycle request to the register file to increment PC (RegSel=PC, FunSel=increment).
REQ-009 IROut  output  16  assembled instruction word.
REQ-010 Valid  output  1  one-cycle pulse: IROut holds a newly completed instruction.
REQ-011 Busy  output  1  high while a fetch is in progress (FETCH_LO or FETCH_HI).

Function
REQ-012 State machine SHALL have states IDLE, FETCH_LO, FETCH_HI, DONE, held in a registered state variable.
REQ-013 IDLE: Start=1 -> latch PCIn into internal 16-bit AddrReg, go to FETCH_LO; Start=0 -> stay.
REQ-014 FETCH_LO: MemAddr=AddrReg, MemRead=1; if MemReady=1, at clock edge IROut[7:0]<=MemData, AddrReg<=AddrReg+1, go to FETCH_HI; else stay with all registers unchanged.
REQ-015 FETCH_HI: MemAddr=AddrReg, MemRead=1; if MemReady=1, at clock edge IROut[15:8]<=MemData, go to DONE; else stay.
REQ-016 DONE: Valid=1 for exactly this cycle; Start=1 -> latch PCIn, go to FETCH_LO; else go to IDLE.
REQ-017 PCInc SHALL be combinational = (state is FETCH_LO or FETCH_HI) AND MemReady, so PC advances by exactly 2 per completed fetch.
REQ-018 Byte order SHALL be little-endian: byte at PC -> IROut[7:0], byte at PC+1 -> IROut[15:8].
REQ-019 AddrReg increment SHALL wrap modulo 2^16 (16'hFFFF + 1 = 16'h0000); no carry output.
REQ-020 MemAddr SHALL be 16'h0000 and MemRead 0 in IDLE and DONE.
REQ-021 Start asserted in FETCH_LO or FETCH_HI SHALL be ignored (not queued).
REQ-022 IROut SHALL hold its last value outside fetch states; IROut[15:8] keeps the previous instruction's high byte during FETCH_HI until written.
REQ-023 PCIn SHALL be sampled only on the Start-accepting edge; later PCIn changes (from PCInc) SHALL NOT affect the in-flight fetch.
REQ-024 Busy SHALL be combinational = state in {FETCH_LO, FETCH_HI}.

Reset
REQ-025 Reset=1 SHALL immediately, without a clock edge, force state=IDLE, AddrReg=16'h0000, IROut=16'h0000; hence Valid=0, Busy=0, MemRead=0, PCInc=0, MemAddr=16'h0000.
REQ-026 Reset asserted mid-fetch SHALL abort the fetch with no Valid pulse; after release the block waits in IDLE for Start.

Verification
REQ-027 Reset, PCIn=16'h0020, mem[0020]=8'h34, mem[0021]=8'h12, MemReady=1, Start pulse -> PCInc high 2 cycles, Valid on 3rd cycle after Start edge, IROut=16'h1234.
REQ-028 PCIn=16'hFFFF, mem[FFFF]=8'hCD, mem[0000]=8'hAB -> MemAddr sequence FFFF, 0000; IROut=16'hABCD.
REQ-029 MemReady=0 for 3 cycles in FETCH_LO -> MemAddr held, PCInc=0, IROut unchanged; fetch completes 3 cycles later than REQ-027 with same result.
REQ-030 Start held high continuously from PCIn=16'h0010 with PC updated by PCInc -> back-to-back fetches at 0010 and 0012, Valid every 3rd cycle, no IDLE cycle.
REQ-031 Reset asserted in FETCH_HI -> outputs zero asynchronously, no Valid; Start after release fetches from new PCIn correctly.
REQ-032 Start pulse during FETCH_LO of an ongoing fetch -> ignored; exactly one Valid pulse, PC advanced by 2.
